// File: rtl/instruction_ram_boot_loader_if.sv
// Byte-stream handshake into the instruction RAM boot loader.
// The master drives byte_in/byte_valid; the loader answers with byte_ready.
interface instruction_ram_boot_loader_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/instruction_ram_boot_loader.sv
// Boot loader: assembles big-endian words from a byte stream into the
// instruction RAM, then hands the RAM address port to CPU fetch.
module instruction_ram_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  instruction_ram_boot_loader_if.slave stream,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  ram_write_enable,
  output logic                  cpu_stall,
  output logic                  load_done
);

  typedef enum logic [1:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] write_ptr;
  logic [ADDR_WIDTH:0]   count;
  logic [1:0]            byte_cnt;
  logic                  ready_q;
  logic                  last_word;

  assign stream.byte_ready = ready_q;
  assign last_word = {1'b0, write_ptr} == count - (ADDR_WIDTH+1)'(1);
  assign ram_address = (state == DONE) ? cpu_address : write_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      write_ptr        <= '0;
      count            <= '0;
      byte_cnt         <= '0;
      ram_write_data   <= '0;
      ready_q          <= 1'b0;
      ram_write_enable <= 1'b0;
      cpu_stall        <= 1'b1;
      load_done        <= 1'b0;
    end else begin
      ram_write_enable <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            count     <= word_count;
            write_ptr <= '0;
            byte_cnt  <= '0;
            if (word_count == '0) begin
              state     <= DONE;
              cpu_stall <= 1'b0;
              load_done <= 1'b1;
            end else begin
              state     <= ASSEMBLE;
              ready_q   <= 1'b1;
              cpu_stall <= 1'b1;
              load_done <= 1'b0;
            end
          end
        end
        ASSEMBLE: begin
          if (stream.byte_valid && ready_q) begin
            // Shifting in from the bottom leaves the first byte in the MSBs.
            ram_write_data <= {ram_write_data[DATA_WIDTH-9:0],
                               stream.byte_in};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              byte_cnt         <= '0;
              state            <= WRITE;
              ready_q          <= 1'b0;
              ram_write_enable <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (last_word) begin
            state     <= DONE;
            cpu_stall <= 1'b0;
            load_done <= 1'b1;
          end else begin
            write_ptr <= write_ptr + ADDR_WIDTH'(1);
            state     <= ASSEMBLE;
            ready_q   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_ram_boot_loader.sv
// Scoreboard bench for the instruction RAM boot loader.
// Drivers queue expected RAM writes; a negedge monitor pops and compares.
module tb_instruction_ram_boot_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] word_count;
  logic [9:0]  cpu_address;
  logic [9:0]  ram_address;
  logic [31:0] ram_write_data;
  logic        ram_write_enable;
  logic        cpu_stall;
  logic        load_done;

  instruction_ram_boot_loader_if bus ();

  instruction_ram_boot_loader dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .word_count       (word_count),
    .stream           (bus),
    .cpu_address      (cpu_address),
    .ram_address      (ram_address),
    .ram_write_data   (ram_write_data),
    .ram_write_enable (ram_write_enable),
    .cpu_stall        (cpu_stall),
    .load_done        (load_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int done_cyc = 0;
  logic [41:0] expq[$];

  always @(posedge clock) cyc++;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clock) begin
    if (reset === 1'b0 && ram_write_enable === 1'b1) begin
      last_wr_cyc = cyc;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                 ram_address, ram_write_data);
      end else begin
        chk("write_addr_data", {22'd0, ram_address, ram_write_data},
            {22'd0, expq.pop_front()});
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit r;
    int t;
    t = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    do begin
      @(negedge clock);
      r = bus.byte_ready;
      @(posedge clock);
      t++;
    end while (!r && t < 100);
    #1;
    bus.byte_valid = 1'b0;
    if (!r) begin
      checks++;
      errors++;
      $display("FAIL byte_accept: timeout, byte %0h not accepted", b);
    end
  endtask

  task automatic send_word(input logic [9:0] a, input logic [31:0] w,
                           input int maxgap);
    expq.push_back({a, w});
    for (int i = 0; i < 4; i++) begin
      if (maxgap > 0) idle($urandom_range(maxgap, 0));
      send_byte(w[31-8*i -: 8]);
    end
  endtask

  task automatic do_start(input int n);
    start      = 1'b1;
    word_count = 11'(n);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (load_done !== 1'b1 && t < 100);
    done_cyc = cyc;
    chk({nm, "_load_done"}, 64'(load_done), 64'd1);
    chk({nm, "_cpu_stall"}, 64'(cpu_stall), 64'd0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    word_count = '0;
    cpu_address = '0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    idle(2);
    chk("rst_byte_ready", 64'(bus.byte_ready), 64'd0);
    chk("rst_we", 64'(ram_write_enable), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd1);
    chk("rst_load_done", 64'(load_done), 64'd0);
    chk("rst_wdata", 64'(ram_write_data), 64'd0);
    chk("rst_ram_addr", 64'(ram_address), 64'd0);

    // start together with reset: reset wins
    start = 1'b1;
    word_count = 11'd1;
    idle(1);
    reset = 1'b0;
    start = 1'b0;
    idle(1);
    chk("rst_start_ready", 64'(bus.byte_ready), 64'd0);
    chk("rst_start_stall", 64'(cpu_stall), 64'd1);

    // two words back-to-back
    do_start(2);
    send_word(10'd0, 32'h6C000000, 0);
    send_word(10'd1, 32'h6840002D, 0);
    wait_done("t1");
    chk("t1_done_latency", 64'(done_cyc - last_wr_cyc), 64'd1);

    // zero-length load
    do_start(0);
    chk("t2_load_done", 64'(load_done), 64'd1);
    chk("t2_byte_ready", 64'(bus.byte_ready), 64'd0);
    idle(3);
    chk("t2_byte_ready_later", 64'(bus.byte_ready), 64'd0);

    // valid gaps 1,0,0,1,1,0,1
    do_start(1);
    expq.push_back({10'd0, 32'h70000000});
    send_byte(8'h70);
    idle(2);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(1);
    send_byte(8'h00);
    wait_done("t3");

    // reset in the middle of word 1
    do_start(3);
    send_word(10'd0, 32'hA1B2C3D4, 0);
    send_byte(8'h11);
    send_byte(8'h22);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("t4_cpu_stall", 64'(cpu_stall), 64'd1);
    chk("t4_load_done", 64'(load_done), 64'd0);
    chk("t4_byte_ready", 64'(bus.byte_ready), 64'd0);
    chk("t4_queue_empty", 64'(expq.size()), 64'd0);
    do_start(1);
    send_word(10'd0, 32'h13579BDF, 0);
    wait_done("t4b");

    // start during ASSEMBLE ignored
    do_start(2);
    expq.push_back({10'd0, 32'hDEADBEEF});
    send_byte(8'hDE);
    send_byte(8'hAD);
    start = 1'b1;
    word_count = 11'd5;
    idle(1);
    start = 1'b0;
    send_byte(8'hBE);
    send_byte(8'hEF);
    send_word(10'd1, 32'h01234567, 0);
    wait_done("t5");

    // CPU owns the address port in DONE
    cpu_address = 10'd5;
    #1;
    chk("t6_cpu_addr", 64'(ram_address), 64'd5);
    do_start(1);
    chk("t6_addr_back", 64'(ram_address), 64'd0);
    chk("t6_stall_back", 64'(cpu_stall), 64'd1);
    send_word(10'd0, 32'hCAFEF00D, 0);
    wait_done("t6");

    // random loads with random byte gaps
    for (int k = 0; k < 8; k++) begin
      int n;
      n = $urandom_range(8, 1);
      do_start(n);
      for (int a = 0; a < n; a++) send_word(10'(a), $urandom, 2);
      wait_done("rnd");
      cpu_address = 10'($urandom);
      #1;
      chk("rnd_cpu_addr", 64'(ram_address), 64'(cpu_address));
    end

    // full RAM: pointer must reach 1023 without wrapping
    do_start(1024);
    for (int a = 0; a < 1024; a++) send_word(10'(a), $urandom, 0);
    wait_done("full");

    idle(3);
    chk("final_queue_empty", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
